int_add_operand_issue: RTL and testbench

- Operand staging and result capture stage wrapped around the 32-bit integer adder `unconfig_int_add`.
- Accepts operand pairs over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents one pair per cycle to the adder from registered outputs, then captures the adder's combinational sum into a result register that the consumer drains over valid/ready.
- Sustains one add per cycle under back-pressure-free conditions.

---
 rtl/int_add_operand_issue_if.sv | 30 +++
 rtl/int_add_operand_issue.sv | 120 ++++++++++++
 tb/tb_int_add_operand_issue.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_add_operand_issue_if.sv
// Handshake bundle between the operand producer, the issue stage, the external
// adder and the result consumer.
interface int_add_operand_issue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_c;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [PTR_W:0]   count;

    modport slave (
        input  in_valid, in_a, in_b, add_c, res_ready,
        output in_ready, add_a, add_b, res_valid, res_data, count
    );

    modport master (
        output in_valid, in_a, in_b, add_c, res_ready,
        input  in_ready, add_a, add_b, res_valid, res_data, count
    );
endinterface

// File: rtl/int_add_operand_issue.sv
// Operand FIFO -> issue register -> result register around an external
// combinational 32-bit adder; one add per cycle without back-pressure.
module int_add_operand_issue #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    int_add_operand_issue_if.slave   bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             iss_valid_q, iss_valid_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;

    logic in_ready_s;
    logic push_s;
    logic adv_res_s;
    logic adv_iss_s;

    // Handshake qualifiers and next-state for every pipeline register.
    always_comb begin
        // in_ready depends only on registered count, never on in_valid.
        in_ready_s = (count_q != FULL_CNT);
        push_s     = bus.in_valid & in_ready_s & rst;
        adv_res_s  = iss_valid_q & (~res_valid_q | bus.res_ready);
        adv_iss_s  = (count_q != '0) & (~iss_valid_q | adv_res_s);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        iss_valid_d = iss_valid_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (adv_iss_s) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            add_a_d     = mem_a_q[rd_ptr_q];
            add_b_d     = mem_b_q[rd_ptr_q];
            iss_valid_d = 1'b1;
        end else if (adv_res_s) begin
            iss_valid_d = 1'b0;
        end else begin
            iss_valid_d = iss_valid_q;
        end

        case ({push_s, adv_iss_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (adv_res_s) begin
            res_data_d  = bus.add_c;
            res_valid_d = 1'b1;
        end else if (res_valid_q & bus.res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // Operand storage; deliberately not reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_q[wr_ptr_q] <= bus.in_a;
            mem_b_q[wr_ptr_q] <= bus.in_b;
        end
    end

    // Pipeline control and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            iss_valid_q <= iss_valid_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_int_add_operand_issue.sv
// Scoreboard bench: accepted pairs push their sum into a queue, a negedge
// monitor pops and compares every consumed result.
module tb_int_add_operand_issue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int_add_operand_issue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    int_add_operand_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural stand-in for the external adder.
    assign bus.add_c = bus.add_a + bus.add_b;

    int vectors     = 0;
    int miscompares = 0;
    int res_seen    = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] pa [10];
    logic [WIDTH-1:0] pb [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: record accepted pairs and check every consumed result.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(bus.in_a + bus.in_b);
            end
            if (bus.res_valid && bus.res_ready) begin
                res_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL result_unexpected: got %0h expected none", bus.res_data);
                end else begin
                    chk("result", bus.res_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic drain(input string name);
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.count == '0 && !bus.res_valid) break;
        end
        tick();
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_count_zero"}, bus.count, 0);
    endtask

    // Fill with res_ready=0 until in_ready drops; leaves in_valid high on a refused pair.
    task automatic fill(output int acc);
        acc = 0;
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pa[i] = $urandom;
            pb[i] = $urandom;
            bus.in_a = pa[i];
            bus.in_b = pb[i];
            @(negedge clk);
            if (!bus.in_ready) break;
            acc++;
            tick();
        end
    endtask

    initial begin
        int acc;
        int r0;
        bit accepted;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;

        #1 rst = 1'b0;
        #2;
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_add_a", bus.add_a, 0);
        chk("rst_add_b", bus.add_b, 0);
        chk("rst_res_data", bus.res_data, 0);
        tick();
        tick();
        rst = 1'b1;

        // Single pair latency.
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'd5;
        bus.in_b      = 32'd7;
        tick();
        bus.in_valid = 1'b0;
        chk("lat_count_after_push", bus.count, 1);
        tick();
        chk("lat_add_a", bus.add_a, 5);
        chk("lat_add_b", bus.add_b, 7);
        chk("lat_count", bus.count, 0);
        chk("lat_res_not_yet", bus.res_valid, 0);
        tick();
        chk("lat_res_valid", bus.res_valid, 1);
        chk("lat_res_data", bus.res_data, 12);
        drain("lat");

        // Back-to-back stream of 8 pairs.
        r0 = res_seen;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'(i);
            bus.in_b     = 32'(10 * i);
            @(negedge clk);
            chk("stream_in_ready", bus.in_ready, 1);
            chk("stream_res_valid", bus.res_valid, (i >= 3) ? 1 : 0);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("stream_tail_res_valid", bus.res_valid, (j <= 2) ? 1 : 0);
            tick();
        end
        chk("stream_result_count", res_seen - r0, 8);
        drain("stream");

        // Back-pressure: DEPTH+2 pairs held, issue register frozen.
        r0 = res_seen;
        fill(acc);
        bus.in_valid = 1'b0;
        chk("bp_accepted", acc, DEPTH + 2);
        chk("bp_count", bus.count, DEPTH);
        chk("bp_add_a", bus.add_a, pa[1]);
        chk("bp_add_b", bus.add_b, pb[1]);
        chk("bp_res_data", bus.res_data, pa[0] + pb[0]);
        tick();
        tick();
        tick();
        chk("bp_add_a_stable", bus.add_a, pa[1]);
        chk("bp_add_b_stable", bus.add_b, pb[1]);
        chk("bp_in_ready_low", bus.in_ready, 0);
        drain("bp");
        chk("bp_result_count", res_seen - r0, DEPTH + 2);

        // Full with a held pair, single-cycle res_ready pulse.
        r0 = res_seen;
        fill(acc);
        chk("hold_accepted", acc, DEPTH + 2);
        bus.in_a = 32'h1234_0000;
        bus.in_b = 32'h0000_4321;
        tick();
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("hold_in_ready_during_pulse", bus.in_ready, 0);
        tick();
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk("hold_in_ready_rise", bus.in_ready, 1);
        chk("hold_one_consumed", res_seen - r0, 1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("hold_count_full", bus.count, DEPTH);
        chk("hold_in_ready_low", bus.in_ready, 0);
        drain("hold");
        chk("hold_result_count", res_seen - r0, DEPTH + 3);

        // Asynchronous reset mid-stream.
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_pair($urandom, $urandom);
        chk("mid_count_before", bus.count, 3);
        chk("mid_res_valid_before", bus.res_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_res_valid_cleared", bus.res_valid, 0);
        chk("mid_count_cleared", bus.count, 0);
        chk("mid_iss_valid_cleared", dut.iss_valid_q, 0);
        chk("mid_in_ready", bus.in_ready, 1);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        r0 = res_seen;
        bus.res_ready = 1'b1;
        push_pair(32'd1, 32'd1);
        for (int t = 0; t < 6; t++) tick();
        chk("mid_single_result", res_seen - r0, 1);
        chk("mid_queue_empty", exp_q.size(), 0);

        // Simultaneous push/pop at count=2 with the write pointer at the wrap.
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        drain("wrap_pre");
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_pair($urandom, $urandom);
        chk("wrap_count_before", bus.count, 2);
        chk("wrap_wr_ptr_before", dut.wr_ptr_q, 3);
        bus.in_valid  = 1'b1;
        bus.in_a      = $urandom;
        bus.in_b      = $urandom;
        bus.res_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("wrap_count_same", bus.count, 2);
        chk("wrap_wr_ptr_wrapped", dut.wr_ptr_q, 0);
        drain("wrap");

        // Randomized traffic with the producer holding refused pairs.
        accepted = 1'b1;
        for (int c = 0; c < 600; c++) begin
            bus.res_ready = (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            if (!bus.in_valid || accepted) begin
                bus.in_valid = ($urandom_range(0, 99) < 70);
                bus.in_a     = $urandom;
                bus.in_b     = $urandom;
            end
            @(negedge clk);
            accepted = bus.in_valid && bus.in_ready;
            tick();
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
